dlfloat_host_link: RTL and testbench



---
 rtl/dlfloat_host_link_if.sv | 38 +++
 rtl/dlfloat_host_link.sv | 121 ++++++++++++
 tb/tb_dlfloat_host_link.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dlfloat_host_link_if.sv
// Host-side bundle for dlfloat_host_link: operand offer, tile bus, result stream.
// Optional NaN-flag signals exist only when DLMAC_LINK_NAN_FLAG_EN is defined.
interface dlfloat_host_link_if;
    logic        op_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_ready;
    logic [15:0] bus_out;
    logic [7:0]  res_byte;
    logic [15:0] res_word;
    logic        res_word_strobe;
    logic        res_valid;
    logic        busy;
`ifdef DLMAC_LINK_NAN_FLAG_EN
    logic        nan_sticky;
    logic [7:0]  nan_count;

    modport master (
        output op_valid, op_a, op_b, res_byte,
        input  op_ready, bus_out, res_word, res_word_strobe, res_valid, busy,
               nan_sticky, nan_count
    );
    modport slave (
        input  op_valid, op_a, op_b, res_byte,
        output op_ready, bus_out, res_word, res_word_strobe, res_valid, busy,
               nan_sticky, nan_count
    );
`else
    modport master (
        output op_valid, op_a, op_b, res_byte,
        input  op_ready, bus_out, res_word, res_word_strobe, res_valid, busy
    );
    modport slave (
        input  op_valid, op_a, op_b, res_byte,
        output op_ready, bus_out, res_word, res_word_strobe, res_valid, busy
    );
`endif
endinterface

// File: rtl/dlfloat_host_link.sv
// Host link for the dlfloat MAC tile: A/B slot multiplexing onto the 16-bit bus and
// byte-serial result reassembly. Define DLMAC_LINK_NAN_FLAG_EN for nan_sticky/nan_count.
module dlfloat_host_link #(
    parameter int unsigned RES_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    dlfloat_host_link_if.slave link
);

    if (RES_LAT < 1 || RES_LAT > 8) begin : g_bad_res_lat
        $error("dlfloat_host_link: RES_LAT must be in 1..8");
    end

    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_t;

    slot_t              slot;
    logic               b_pending;
    logic [15:0]        hold_b;
    logic [15:0]        bus_q;
    logic [RES_LAT-1:0] tag_line;

    logic               byte_phase;
    logic               have_hi;
    logic [7:0]         hi;
    logic [15:0]        word_q;
    logic               strobe_q;
    logic               valid_q;

    logic               accept;
    logic [15:0]        word_next;
    logic               word_done;

    assign link.op_ready = (slot == SLOT_B) && !rst;
    assign accept        = link.op_valid && link.op_ready;
    assign link.busy     = b_pending || (|tag_line);
    assign word_next     = {hi, link.res_byte};
    assign word_done     = !byte_phase && have_hi;

    // Issue path: A goes out in the slot after accept, B (or 0) in the one after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= SLOT_A;
            bus_q     <= '0;
            hold_b    <= '0;
            b_pending <= 1'b0;
            tag_line  <= '0;
        end else if (slot == SLOT_B) begin
            slot <= SLOT_A;
            if (accept) begin
                bus_q     <= link.op_a;
                hold_b    <= link.op_b;
                b_pending <= 1'b1;
            end else begin
                bus_q     <= '0;
                b_pending <= 1'b0;
            end
        end else begin
            slot      <= SLOT_B;
            bus_q     <= b_pending ? hold_b : '0;
            b_pending <= 1'b0;
            tag_line  <= (tag_line << 1) | RES_LAT'(b_pending);
        end
    end

    // Collect path; tag_line is read before the same-edge shift, which sets the latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_phase <= 1'b0;
            have_hi    <= 1'b0;
            hi         <= '0;
            word_q     <= '0;
            strobe_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            byte_phase <= ~byte_phase;
            strobe_q   <= 1'b0;
            valid_q    <= 1'b0;
            if (byte_phase) begin
                hi      <= link.res_byte;
                have_hi <= 1'b1;
            end else if (have_hi) begin
                word_q   <= word_next;
                strobe_q <= 1'b1;
                valid_q  <= tag_line[RES_LAT-1];
            end
        end
    end

    assign link.bus_out         = bus_q;
    assign link.res_word        = word_q;
    assign link.res_word_strobe = strobe_q;
    assign link.res_valid       = valid_q;

`ifdef DLMAC_LINK_NAN_FLAG_EN
    logic       nan_q;
    logic [7:0] nan_cnt_q;
    logic       nan_hit;

    assign nan_hit = word_done && (word_next == 16'hFFFF) && tag_line[RES_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_q     <= 1'b0;
            nan_cnt_q <= '0;
        end else if (nan_hit) begin
            nan_q <= 1'b1;
            if (nan_cnt_q != 8'hFF) begin
                nan_cnt_q <= nan_cnt_q + 8'd1;
            end
        end
    end

    assign link.nan_sticky = nan_q;
    assign link.nan_count  = nan_cnt_q;
`endif

endmodule

// File: tb/tb_dlfloat_host_link.sv
// Self-checking bench for dlfloat_host_link: cycle-indexed model of slot/byte phases
// with a scoreboard of expected result words.
module tb_dlfloat_host_link;

    localparam int RES_LAT = 2;
    localparam int NCYC    = 256;

    typedef struct {
        logic [15:0] word;
        logic        valid;
    } exp_t;

    logic clk;
    logic rst;

    dlfloat_host_link_if link();

    dlfloat_host_link #(.RES_LAT(RES_LAT)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          k;
    logic        acc     [NCYC];
    logic [15:0] exp_bus [NCYC];
    logic [15:0] wtab    [NCYC];
    exp_t        sb[$];
    logic        nan_m;
    int          nan_cnt_m;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCYC; i++) begin
            acc[i]     = 1'b0;
            exp_bus[i] = '0;
            wtab[i]    = {8'(i), 8'(i) ^ 8'h5A};
        end
        sb.delete();
        nan_m     = 1'b0;
        nan_cnt_m = 0;
        k         = 0;
    endtask

    // Assert reset now (just after a rising edge), check cleared outputs, release after ncyc edges.
    task automatic do_reset(input int ncyc);
        rst           = 1'b1;
        link.op_valid = 1'b0;
        #1;
        check("rst_bus_out",  link.bus_out, 16'h0000);
        check("rst_busy",     link.busy, 1'b0);
        check("rst_op_ready", link.op_ready, 1'b0);
        check("rst_res_word", link.res_word, 16'h0000);
        check("rst_strobe",   link.res_word_strobe, 1'b0);
        check("rst_valid",    link.res_valid, 1'b0);
`ifdef DLMAC_LINK_NAN_FLAG_EN
        check("rst_nan_sticky", link.nan_sticky, 1'b0);
        check("rst_nan_count",  link.nan_count, 16'd0);
`endif
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic run_cycle(input logic v, input logic [15:0] a, input logic [15:0] b);
        logic exp_busy;
        exp_t e;
        link.op_valid = v;
        link.op_a     = a;
        link.op_b     = b;
        link.res_byte = (k % 2 == 1) ? wtab[k+1][15:8] : wtab[k][7:0];
        @(negedge clk);
        check("op_ready", link.op_ready, (k % 2 == 1));
        check("bus_out", link.bus_out, exp_bus[k]);
        exp_busy = 1'b0;
        for (int j = k - 1 - 2 * RES_LAT; j < k; j++)
            if (j >= 0 && acc[j]) exp_busy = 1'b1;
        check("busy", link.busy, exp_busy);
        if (k % 2 == 1 && k >= 3) begin
            check("strobe", link.res_word_strobe, 1'b1);
            if (sb.size() == 0) begin
                check("sb_empty", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("res_word", link.res_word, e.word);
                check("res_valid", link.res_valid, e.valid);
                if (e.valid && e.word == 16'hFFFF) begin
                    nan_m = 1'b1;
                    if (nan_cnt_m < 255) nan_cnt_m++;
                end
`ifdef DLMAC_LINK_NAN_FLAG_EN
                check("nan_sticky", link.nan_sticky, nan_m);
                check("nan_count",  link.nan_count, 16'(nan_cnt_m));
`endif
            end
        end else begin
            check("no_strobe", link.res_word_strobe, 1'b0);
            check("no_valid",  link.res_valid, 1'b0);
        end
        if (k % 2 == 1) begin
            e.word  = wtab[k+1];
            e.valid = (k - 2 * RES_LAT >= 0) ? acc[k - 2 * RES_LAT] : 1'b0;
            sb.push_back(e);
            if (v) begin
                acc[k]       = 1'b1;
                exp_bus[k+1] = a;
                exp_bus[k+2] = b;
            end
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        link.op_valid = 1'b0;
        link.op_a     = '0;
        link.op_b     = '0;
        link.res_byte = '0;
        clear_model();
        @(posedge clk);
        do_reset(2);

        // idle: bus stays zero, strobes from cycle 3, no res_valid
        repeat (10) run_cycle(1'b0, 16'h0, 16'h0);
        // op_valid held: accepts on every odd cycle
        repeat (10) run_cycle(1'b1, 16'h3E00, 16'h3E00);
        repeat (21) run_cycle(1'b0, 16'h0, 16'h0);
        // single pair accepted at cycle 41
        run_cycle(1'b1, 16'h3E00, 16'h4000);
        repeat (8) run_cycle(1'b0, 16'h0, 16'h0);
        // op_valid only in a slot=0 cycle (cycle 50)
        run_cycle(1'b1, 16'h1111, 16'h2222);
        run_cycle(1'b0, 16'h0, 16'h0);
        // result byte assembly and NaN pass-through on a valid word
        wtab[60] = 16'hABCD;
        wtab[66] = 16'hFFFF;
        repeat (9) run_cycle(1'b0, 16'h0, 16'h0);
        run_cycle(1'b1, 16'hFFFF, 16'hFFFF);
        repeat (19) run_cycle(1'b0, 16'h0, 16'h0);
        // accept at cycle 81, reset before its B slot
        run_cycle(1'b1, 16'h1234, 16'h5678);
        do_reset(1);
        repeat (24) run_cycle(1'b0, 16'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
